// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled
//   Oversampling UART receiver for 8N1 frames, LSB first. It sits behind the
//   baud tick generator and hands each received byte to the downstream
//   consumer with a one-cycle done strobe and a framing-error flag.
//
// Parameters
//   DATA_BITS   data bits per frame (5..8)
//   OVERSAMPLE  Tick pulses per bit period (even, >= 4)
//
// Ports
//   Clk       system clock
//   Rst_n     synchronous active-low reset
//   Tick      oversample strobe, one Clk wide, OVERSAMPLE per bit period
//   Rx        asynchronous serial line, idle high
//   RxData    last received byte, held until the next completed frame
//   RxDone    one-Clk pulse when a frame completes
//   FrameErr  stop bit was sampled low; valid with RxDone, held until the next
//   Busy      receiver is in any state other than IDLE
module uart_rx_oversampled #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Tick,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxDone,
  output logic                 FrameErr,
  output logic                 Busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state, state_n;
  logic                 rx_meta, rx_s, rx_prev;
  logic                 fall;
  logic [TW-1:0]        tick_cnt, tick_cnt_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 done_n, ferr_n;

  // Edge detect runs every Clk so a start edge is never missed between Ticks.
  // A line held low cannot retrigger: the detector needs a prior 1.
  assign fall = rx_prev & ~rx_s;
  assign Busy = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      RxData   <= '0;
      RxDone   <= 1'b0;
      FrameErr <= 1'b0;
    end else begin
      rx_meta  <= Rx;
      rx_s     <= rx_meta;
      rx_prev  <= rx_s;
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      RxData   <= data_n;
      RxDone   <= done_n;
      FrameErr <= ferr_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    data_n     = RxData;
    done_n     = 1'b0;
    ferr_n     = FrameErr;

    case (state)
      IDLE: begin
        if (fall) begin
          state_n    = START;
          tick_cnt_n = '0;
        end
      end

      START: begin
        if (Tick) begin
          if (tick_cnt == TICK_MID) begin
            if (!rx_s) begin
              state_n    = DATA;
              tick_cnt_n = '0;
              bit_cnt_n  = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end

      DATA: begin
        if (Tick) begin
          if (tick_cnt == TICK_LAST) begin
            shift_n    = {rx_s, shift[DATA_BITS-1:1]};
            tick_cnt_n = '0;
            if (bit_cnt == BIT_LAST) begin
              state_n = STOP;
            end else begin
              bit_cnt_n = bit_cnt + 1'b1;
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end

      STOP: begin
        if (Tick) begin
          if (tick_cnt == TICK_LAST) begin
            // Leaving at mid stop bit lets an immediately following start
            // edge be accepted.
            state_n = IDLE;
            done_n  = 1'b1;
            data_n  = shift;
            ferr_n  = ~rx_s;
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Testbench for uart_rx_oversampled. Tick is generated every TICK_DIV clocks
// so a bit lasts TICK_DIV*16 clocks. Frames are serialised from byte values;
// the expected byte/framing-error pairs go into a queue that a monitor drains
// on every RxDone.
module tb_uart_rx_oversampled;

  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = TICK_DIV * 16;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       Tick;
  logic       Rx;
  logic [7:0] RxData;
  logic       RxDone;
  logic       FrameErr;
  logic       Busy;

  logic [1:0] div = '0;
  logic       tick_en = 1'b1;

  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;

  logic [8:0] exp_q[$];   // {frame_err, byte}
  int         done_cyc[$];
  logic [7:0] last_data = '0;
  logic       prev_done = 1'b0;
  logic       prev_busy = 1'b0;
  logic       busy_seen = 1'b0;

  uart_rx_oversampled #(
    .DATA_BITS (8),
    .OVERSAMPLE(16)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Tick    (Tick),
    .Rx      (Rx),
    .RxData  (RxData),
    .RxDone  (RxDone),
    .FrameErr(FrameErr),
    .Busy    (Busy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    div <= div + 2'd1;
    cyc <= cyc + 1;
  end
  assign Tick = tick_en && (div == 2'd0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Monitor: every RxDone must match the oldest expected frame.
  always @(negedge Clk) begin
    logic [8:0] e;
    if (RxDone) begin
      check("done_not_consecutive", {31'd0, prev_done}, 32'd0);
      check("busy_low_with_done", {31'd0, Busy}, 32'd0);
      check("busy_before_done", {31'd0, prev_busy}, 32'd1);
      done_cyc.push_back(cyc);
      check("done_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rxdata", {24'd0, RxData}, {24'd0, e[7:0]});
        check("frameerr", {31'd0, FrameErr}, {31'd0, e[8]});
        last_data = e[7:0];
      end
    end
    if (Busy) busy_seen = 1'b1;
    prev_done = RxDone;
    prev_busy = Busy;
  end

  // Serialise one frame. stall_bit >= 0 gates Tick off for 1000 clocks in the
  // middle of that data bit while the line is held.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int stall_bit);
    exp_q.push_back({~stop, b});
    Rx = 1'b0;
    clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      Rx = b[i];
      if (i == stall_bit) begin
        clks(BIT_CLKS / 2);
        tick_en = 1'b0;
        clks(1000);
        check("stall_busy_held", {31'd0, Busy}, 32'd1);
        tick_en = 1'b1;
        clks(BIT_CLKS / 2);
      end else begin
        clks(BIT_CLKS);
      end
    end
    Rx = stop;
    clks(BIT_CLKS);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 4 * BIT_CLKS) begin
      @(posedge Clk);
      n++;
    end
    #1;
    check("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       bad;

    Rst_n = 1'b0;
    Rx    = 1'b1;
    clks(3);
    check("reset_rxdata", {24'd0, RxData}, 32'd0);
    check("reset_rxdone", {31'd0, RxDone}, 32'd0);
    check("reset_frameerr", {31'd0, FrameErr}, 32'd0);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    Rst_n = 1'b1;
    clks(2 * BIT_CLKS);

    // Single byte
    send_frame(8'hA5, 1'b1, -1);
    wait_drain();
    clks(BIT_CLKS);

    // Glitch shorter than half a bit
    busy_seen = 1'b0;
    Rx = 1'b0;
    clks(4 * TICK_DIV);
    Rx = 1'b1;
    clks(2 * BIT_CLKS);
    check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
    check("glitch_busy_idle", {31'd0, Busy}, 32'd0);
    check("glitch_rxdata_held", {24'd0, RxData}, {24'd0, last_data});

    // Framing error followed by a held break, then a good frame
    send_frame(8'h3C, 1'b0, -1);
    clks(3 * BIT_CLKS);
    check("break_busy_idle", {31'd0, Busy}, 32'd0);
    Rx = 1'b1;
    clks(2 * BIT_CLKS);
    send_frame(8'h55, 1'b1, -1);
    wait_drain();
    clks(BIT_CLKS);

    // Back-to-back frames
    done_cyc.delete();
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    send_frame(8'h81, 1'b1, -1);
    wait_drain();
    check("b2b_count", done_cyc.size(), 32'd3);
    for (int i = 1; i < done_cyc.size(); i++) begin
      int d;
      d = done_cyc[i] - done_cyc[i-1];
      check("b2b_spacing_ok", {31'd0, (d >= 10 * BIT_CLKS - TICK_DIV && d <= 10 * BIT_CLKS + TICK_DIV)}, 32'd1);
    end
    clks(BIT_CLKS);

    // Reset during data bit 4 of 0x96; the rest of the frame is abandoned
    begin
      logic [7:0] r;
      r = 8'h96;
      Rx = 1'b0;
      clks(BIT_CLKS);
      for (int i = 0; i < 4; i++) begin
        Rx = r[i];
        clks(BIT_CLKS);
      end
      Rx = r[4];
      clks(BIT_CLKS / 2);
      Rst_n = 1'b0;
      clks(1);
      check("midreset_rxdata", {24'd0, RxData}, 32'd0);
      check("midreset_rxdone", {31'd0, RxDone}, 32'd0);
      check("midreset_frameerr", {31'd0, FrameErr}, 32'd0);
      check("midreset_busy", {31'd0, Busy}, 32'd0);
      clks(1);
      Rst_n = 1'b1;
      last_data = 8'h00;
      Rx = 1'b1;
      clks(12 * BIT_CLKS);
      check("midreset_no_done", exp_q.size(), 32'd0);
    end
    send_frame(8'h42, 1'b1, -1);
    wait_drain();
    clks(BIT_CLKS);

    // Tick stall in the middle of a data bit
    send_frame(8'hC9, 1'b1, 3);
    wait_drain();
    clks(BIT_CLKS);

    // Randomised frames with occasional framing errors and random gaps
    for (int k = 0; k < 12; k++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      send_frame(b, ~bad, -1);
      if (bad) begin
        Rx = 1'b1;
        clks(BIT_CLKS);
      end else begin
        clks($urandom_range(0, 2 * BIT_CLKS));
      end
    end
    wait_drain();
    clks(2 * BIT_CLKS);
    check("final_idle", {31'd0, Busy}, 32'd0);
    check("final_rxdata", {24'd0, RxData}, {24'd0, last_data});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
